// File: rtl/sha256_pkg.sv
// ----------------------------------------------------------------------------
// sha256_pkg
// Shared definitions for the SHA-256 message front end:
//   - FSM state encoding for sha256_msg_packer
//   - block geometry constants (MAX_MSG_BYTES, BLOCK_WORDS, PAD_BYTE)
//   - pad_byte(): value of one byte of the padded single-block message
// ----------------------------------------------------------------------------
package sha256_pkg;

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_COLLECT   = 2'd1;
   localparam logic [1:0] S_WAIT_CORE = 2'd2;
   localparam logic [1:0] S_SEND      = 2'd3;

   localparam int         MAX_MSG_BYTES = 55;
   localparam int         BLOCK_WORDS   = 16;
   localparam logic [7:0] PAD_BYTE      = 8'h80;

   // Byte j of the padded block for a message of len bytes. data is the
   // stored buffer byte at position j; it is only used when j < len, so
   // stale bytes from an earlier, longer message never leak out.
   // len*8 is at most 440, so only the two lowest length bytes (62, 63)
   // can ever be non-zero.
   function automatic logic [7:0] pad_byte(input logic [5:0] j,
                                           input logic [5:0] len,
                                           input logic [7:0] data);
      logic [15:0] len_bits;
      len_bits = {7'd0, len, 3'd0};
      if (j < len)             return data;
      else if (j == len)       return PAD_BYTE;
      else if (j == 6'd62)     return len_bits[15:8];
      else if (j == 6'd63)     return len_bits[7:0];
      else                     return 8'h00;
   endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// ----------------------------------------------------------------------------
// sha256_pad_word
// Purely combinational: builds padded block word w from the four stored
// message bytes at positions 4w..4w+3 and the message length.
// Ports:
//   word_idx  in  4   word index w (0..15)
//   msg_len   in  6   message length L in bytes (0..55)
//   buf_word  in  32  stored bytes 4w..4w+3, byte 4w in the MSBs
//   pad_word  out 32  padded word, big-endian
// ----------------------------------------------------------------------------
module sha256_pad_word
   import sha256_pkg::*;
(
   input  logic [3:0]  word_idx,
   input  logic [5:0]  msg_len,
   input  logic [31:0] buf_word,
   output logic [31:0] pad_word
);

   // NOTE: every always_comb output gets a default before any branch so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      pad_word = '0;
      for (int k = 0; k < 4; k++) begin
         pad_word[31-8*k -: 8] = pad_byte({word_idx, 2'(k)}, msg_len,
                                          buf_word[31-8*k -: 8]);
      end
   end

endmodule

// File: rtl/sha256_msg_packer.sv
// ----------------------------------------------------------------------------
// sha256_msg_packer
// Receives a length-prefixed byte stream (length byte, then L data bytes,
// L = 0..55), stores it, and once the SHA-256 core is idle delivers the
// 16-word single-block padded message, one word per cycle.
// Optional feature macro: MP_TIMEOUT_EN -- aborts a message whose bytes stop
// arriving for TIMEOUT_CYCLES cycles while collecting.
// Parameters:
//   DATA_WIDTH      word width toward the core (must be 32)
//   TIMEOUT_CYCLES  inter-byte timeout, used only with MP_TIMEOUT_EN
// Ports:
//   clk           in   1   system clock
//   rst           in   1   asynchronous reset, active-high
//   Rx_dv_in      in   1   Rx_byte_in valid (one-cycle pulse)
//   Rx_byte_in    in   8   received byte
//   core_idle_in  in   1   core can accept a new block
//   message_out   out  32  padded block word, big-endian
//   MP_dv_out     out  1   message_out valid (16 back-to-back pulses/block)
//   busy_out      out  1   high whenever not idle
//   error_out     out  1   one-cycle error pulse
// ----------------------------------------------------------------------------
module sha256_msg_packer
   import sha256_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  Rx_dv_in,
   input  logic [7:0]            Rx_byte_in,
   input  logic                  core_idle_in,
   output logic [DATA_WIDTH-1:0] message_out,
   output logic                  MP_dv_out,
   output logic                  busy_out,
   output logic                  error_out
);

   logic [1:0]  state_q, state_d;
   logic [5:0]  len_q,   len_d;
   logic [5:0]  cnt_q,   cnt_d;
   logic [3:0]  word_q,  word_d;
   logic [DATA_WIDTH-1:0] msg_q, msg_d;
   logic        dv_q,    dv_d;
   logic        busy_q,  busy_d;
   logic        err_q,   err_d;

   // Message buffer held as 16 big-endian words so the word being sent is a
   // plain index; byte j lives in word j/4, lane 3 - j%4.
   logic [BLOCK_WORDS-1:0][31:0] buf_q, buf_d;

   logic [31:0] pad_word;

`ifdef MP_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

   sha256_pad_word u_pad_word (
      .word_idx (word_q),
      .msg_len  (len_q),
      .buf_word (buf_q[word_q]),
      .pad_word (pad_word)
   );

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      buf_d   = buf_q;
      msg_d   = '0;     // word bus is zero whenever MP_dv_out is low
      dv_d    = 1'b0;
      err_d   = 1'b0;
`ifdef MP_TIMEOUT_EN
      tmo_d   = tmo_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (Rx_dv_in) begin
               if (Rx_byte_in > 8'(MAX_MSG_BYTES)) begin
                  err_d = 1'b1;
               end else if (Rx_byte_in == 8'd0) begin
                  len_d   = 6'd0;
                  state_d = S_WAIT_CORE;
               end else begin
                  len_d   = Rx_byte_in[5:0];
                  cnt_d   = 6'd0;
                  state_d = S_COLLECT;
`ifdef MP_TIMEOUT_EN
                  tmo_d   = '0;
`endif
               end
            end
         end

         S_COLLECT: begin
            if (Rx_dv_in) begin
               buf_d[cnt_q[5:2]][{~cnt_q[1:0], 3'b000} +: 8] = Rx_byte_in;
               cnt_d = cnt_q + 6'd1;
               if (cnt_q + 6'd1 == len_q) state_d = S_WAIT_CORE;
`ifdef MP_TIMEOUT_EN
               tmo_d = '0;
            end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
               // TIMEOUT_CYCLES silent cycles: drop the partial message.
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
`endif
            end
         end

         S_WAIT_CORE: begin
            if (Rx_dv_in) err_d = 1'b1;
            if (core_idle_in) begin
               word_d  = 4'd0;
               state_d = S_SEND;
            end
         end

         S_SEND: begin
            // core_idle_in is deliberately ignored: the block always goes
            // out as 16 contiguous words once started.
            if (Rx_dv_in) err_d = 1'b1;
            dv_d   = 1'b1;
            msg_d  = pad_word;
            word_d = word_q + 4'd1;
            if (word_q == 4'(BLOCK_WORDS - 1)) state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         word_q  <= '0;
         msg_q   <= '0;
         dv_q    <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef MP_TIMEOUT_EN
         tmo_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         msg_q   <= msg_d;
         dv_q    <= dv_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
`ifdef MP_TIMEOUT_EN
         tmo_q   <= tmo_d;
`endif
      end
   end

   // NOTE: the message buffer is storage, not control; it has no reset
   // because bytes at j >= L are always replaced by padding, so stale or
   // unknown contents can never reach message_out.
   always_ff @(posedge clk) begin
      buf_q <= buf_d;
   end

   assign message_out = msg_q;
   assign MP_dv_out   = dv_q;
   assign busy_out    = busy_q;
   assign error_out   = err_q;

endmodule

// File: tb/tb_sha256_msg_packer.sv
// ----------------------------------------------------------------------------
// tb_sha256_msg_packer
// Self-checking bench for sha256_msg_packer: directed vector table, hand
// sequences for over-length, back-pressure, late bytes, mid-message reset
// and (with MP_TIMEOUT_EN) timeout, then randomized messages checked
// against a padded-block reference model.
// ----------------------------------------------------------------------------
module tb_sha256_msg_packer;

   logic        clk;
   logic        rst;
   logic        Rx_dv_in;
   logic [7:0]  Rx_byte_in;
   logic        core_idle_in;
   logic [31:0] message_out;
   logic        MP_dv_out;
   logic        busy_out;
   logic        error_out;

   sha256_msg_packer #(
      .DATA_WIDTH     (32),
      .TIMEOUT_CYCLES (50)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .Rx_dv_in     (Rx_dv_in),
      .Rx_byte_in   (Rx_byte_in),
      .core_idle_in (core_idle_in),
      .message_out  (message_out),
      .MP_dv_out    (MP_dv_out),
      .busy_out     (busy_out),
      .error_out    (error_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc      = 0;
   int          err_cnt  = 0;
   bit          busy_seen = 0;
   bit          drop_idle = 0;
   logic [31:0] got[$];
   int          got_cyc[$];
   logic [7:0]  cur_msg[$];

   // Output monitor, sampling 1 time unit after the active edge.
   always @(posedge clk) begin
      #1;
      if (MP_dv_out) begin
         got.push_back(message_out);
         got_cyc.push_back(cyc);
      end
      if (error_out) err_cnt++;
      if (busy_out)  busy_seen = 1;
      cyc++;
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference: standard SHA-256 single-block padding of cur_msg, with the
   // full 64-bit big-endian bit length in bytes 56..63.
   function automatic logic [31:0] model_word(input int w);
      logic [7:0]      blk [64];
      longint unsigned bits;
      int              len;
      len = cur_msg.size();
      for (int i = 0; i < 64; i++)  blk[i] = 8'h00;
      for (int i = 0; i < len; i++) blk[i] = cur_msg[i];
      blk[len] = 8'h80;
      bits = longint'(len) * 8;
      for (int k = 0; k < 8; k++) blk[56+k] = 8'(bits >> (8 * (7 - k)));
      return {blk[4*w], blk[4*w+1], blk[4*w+2], blk[4*w+3]};
   endfunction

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      Rx_dv_in   = 1'b1;
      Rx_byte_in = b;
      @(negedge clk);
      Rx_dv_in   = 1'b0;
      Rx_byte_in = 8'h00;
   endtask

   task automatic send_msg(input bit gaps);
      send_byte(8'(cur_msg.size()));
      foreach (cur_msg[i]) begin
         if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
         send_byte(cur_msg[i]);
      end
   endtask

   // Waits (bounded) for a full block and compares it against the model.
   task automatic run_block(input string name);
      int budget;
      budget = 0;
      while (got.size() < 16 && budget < 400) begin
         @(negedge clk);
         budget++;
         if (drop_idle && got.size() > 0) core_idle_in = 1'b0;
      end
      repeat (4) @(negedge clk);
      check({name, " word count"}, 32'(got.size()), 32'd16);
      if (got.size() >= 16) begin
         for (int w = 0; w < 16; w++)
            check($sformatf("%s word %0d", name, w), got[w], model_word(w));
         check({name, " back-to-back"}, 32'(got_cyc[15] - got_cyc[0]), 32'd15);
      end
      check({name, " busy low after block"}, 32'(busy_out), 32'd0);
   endtask

   task automatic clear_obs();
      got.delete();
      got_cyc.delete();
      err_cnt   = 0;
      busy_seen = 0;
   endtask

   typedef struct {
      string       name;
      int          len;
      logic [7:0]  start;
      int          i0; logic [31:0] e0;
      int          i1; logic [31:0] e1;
      int          i2; logic [31:0] e2;
   } vec_t;

   vec_t tbl[5];

   initial begin
      tbl[0] = '{"abc",   3, 8'h61, 0, 32'h61626380, 1,  32'h00000000, 15, 32'h00000018};
      tbl[1] = '{"empty", 0, 8'h00, 0, 32'h80000000, 14, 32'h00000000, 15, 32'h00000000};
      tbl[2] = '{"max55", 55, 8'h00, 13, 32'h34353680, 14, 32'h00000000, 15, 32'h000001B8};
      tbl[3] = '{"len4",  4, 8'h10, 0, 32'h10111213, 1,  32'h80000000, 15, 32'h00000020};
      tbl[4] = '{"len52", 52, 8'hA0, 12, 32'hD0D1D2D3, 13, 32'h80000000, 15, 32'h000001A0};

      rst          = 1'b1;
      Rx_dv_in     = 1'b0;
      Rx_byte_in   = 8'h00;
      core_idle_in = 1'b0;

      // Reset state
      #2;
      check("reset message_out", message_out, 32'h0);
      check("reset MP_dv_out",   32'(MP_dv_out), 32'd0);
      check("reset busy_out",    32'(busy_out),  32'd0);
      check("reset error_out",   32'(error_out), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Directed vector table
      for (int t = 0; t < 5; t++) begin
         cur_msg.delete();
         for (int i = 0; i < tbl[t].len; i++) cur_msg.push_back(8'(tbl[t].start + 8'(i)));
         core_idle_in = 1'b1;
         clear_obs();
         send_msg(1'b0);
         run_block(tbl[t].name);
         if (got.size() >= 16) begin
            check({tbl[t].name, " table a"}, got[tbl[t].i0], tbl[t].e0);
            check({tbl[t].name, " table b"}, got[tbl[t].i1], tbl[t].e1);
            check({tbl[t].name, " table c"}, got[tbl[t].i2], tbl[t].e2);
         end
         check({tbl[t].name, " no error"}, 32'(err_cnt), 32'd0);
      end

      // Over-length: one error pulse, never busy, no words
      clear_obs();
      send_byte(8'h38);
      check("overlen error timing", 32'(error_out), 32'd1);
      repeat (10) @(negedge clk);
      check("overlen error pulses", 32'(err_cnt), 32'd1);
      check("overlen busy seen",    32'(busy_seen), 32'd0);
      check("overlen words",        32'(got.size()), 32'd0);

      // Back-pressure with a byte injected while waiting for the core
      cur_msg.delete();
      for (int i = 0; i < 10; i++) cur_msg.push_back(8'($urandom));
      core_idle_in = 1'b0;
      clear_obs();
      send_msg(1'b0);
      repeat (50) @(negedge clk);
      send_byte(8'hAA);
      repeat (49) @(negedge clk);
      check("backpressure no words",   32'(got.size()), 32'd0);
      check("backpressure busy",       32'(busy_out),   32'd1);
      check("backpressure error",      32'(err_cnt),    32'd1);
      core_idle_in = 1'b1;
      run_block("backpressure");
      check("backpressure error total", 32'(err_cnt), 32'd1);

      // Byte arriving during S_SEND: dropped, block intact
      cur_msg.delete();
      for (int i = 0; i < 20; i++) cur_msg.push_back(8'($urandom));
      clear_obs();
      send_msg(1'b0);
      for (int b = 0; b < 50 && got.size() == 0; b++) @(negedge clk);
      send_byte(8'h55);
      run_block("late byte");
      check("late byte error", 32'(err_cnt), 32'd1);

      // Reset after 2 of 5 data bytes
      clear_obs();
      send_byte(8'd5);
      send_byte(8'h11);
      send_byte(8'h22);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midreset message_out", message_out, 32'h0);
      check("midreset MP_dv_out",   32'(MP_dv_out), 32'd0);
      check("midreset busy_out",    32'(busy_out),  32'd0);
      check("midreset error_out",   32'(error_out), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      check("midreset no words", 32'(got.size()), 32'd0);
      cur_msg = '{8'h61, 8'h62, 8'h63};
      clear_obs();
      send_msg(1'b0);
      run_block("abc after reset");

`ifdef MP_TIMEOUT_EN
      // Stalled message with TIMEOUT_CYCLES = 50
      clear_obs();
      send_byte(8'd5);
      send_byte(8'h01);
      send_byte(8'h02);
      repeat (60) @(negedge clk);
      check("timeout error",    32'(err_cnt),    32'd1);
      check("timeout busy low", 32'(busy_out),   32'd0);
      check("timeout no words", 32'(got.size()), 32'd0);
      cur_msg = '{8'h61, 8'h62, 8'h63};
      clear_obs();
      send_msg(1'b0);
      run_block("abc after timeout");
`endif

      // Randomized messages
      for (int n = 0; n < 25; n++) begin
         int len;
         len = $urandom_range(0, 55);
         cur_msg.delete();
         for (int i = 0; i < len; i++) cur_msg.push_back(8'($urandom));
         core_idle_in = 1'b0;
         drop_idle    = ($urandom_range(0, 1) == 1);
         clear_obs();
         send_msg(1'b1);
         repeat ($urandom_range(0, 5)) @(negedge clk);
         core_idle_in = 1'b1;
         run_block($sformatf("random %0d len %0d", n, len));
         check($sformatf("random %0d no error", n), 32'(err_cnt), 32'd0);
         drop_idle = 0;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
